mant_addsub_norm: RTL and testbench
===================================

// Module: mant_addsub_norm
// PURPOSE
//  Parametrised sign-magnitude mantissa adder/subtractor with built-in leading-one normaliser.
//  It sits in the FP datapath between exponent alignment and rounding.
//  Accepts aligned mantissas, computes the signed result and left-normalises it one bit per cycle.
//  It reports the shift count so the exponent unit can adjust. Handshake: load in, ready out.
// PARAMETERS
//  WIDTH    24  mantissa magnitude width (incl. hidden bit)
//  SHIFT_W  5   width of norm_shift; must satisfy 2**SHIFT_W > WIDTH-1
//  NORM_EN  1   1 = run normalise phase; 0 = skip it (norm_shift stays 0)
// PORTS
//  clk         in   1        clock, all state on rising edge
//  rst         in   1        reset, asynchronous, active-low
//  en          in   1        clock enable; 0 freezes every register
//  load        in   1        start request; sampled only when en=1 and not busy
//  op          in   1        0 = A+B, 1 = A-B
//  a           in   WIDTH    magnitude of A
//  b           in   WIDTH    magnitude of B
//  sign_a      in   1        sign of A (1 = negative)
//  sign_b      in   1        sign of B (1 = negative)
//  sum         out  WIDTH    result magnitude (normalised if NORM_EN)
//  c_out       out  1        magnitude carry-out (effective add only)
//  sign_s      out  1        result sign
//  norm_shift  out  SHIFT_W  left shifts applied during normalisation
//  zero        out  1        result magnitude is zero
//  busy        out  1        1 in ADD/NORM states
//  ready       out  1        1 in DONE state; outputs valid
// BEHAVIOUR
//  Reset (rst=0, async): state IDLE. sum, c_out, sign_s, norm_shift, zero, busy and ready all 0.
//  Reset mid-operation aborts with no residue.
//  FSM: IDLE -> ADD -> (NORM)* -> DONE. All transitions require en=1.
//   With en=0 state and outputs hold.
//  IDLE/DONE, en&load: capture a, b, sign_a, sign_b, op. Go to ADD. ready<=0, busy<=1.
//  Load in DONE restarts identically. load in ADD/NORM is ignored.
//  ADD (1 cycle): eff_sub = op ^ sign_a ^ sign_b.
//   Effective add: {c_out,sum} = a+b (WIDTH+1 bits); sign_s = sign_a.
//   Effective sub: if a>=b, sum = a-b and sign_s = sign_a.
//    Otherwise sum = b-a and sign_s = sign_b ^ op. c_out = 0.
//   Zero result: zero=1, sign_s=0 (positive zero).
//   Next state is DONE if any of: NORM_EN=0, c_out=1, zero=1, sum[WIDTH-1]=1. Otherwise NORM.
//  NORM: each en cycle, sum <= sum<<1 and norm_shift <= norm_shift+1.
//   Exit to DONE on the edge where the shifted sum has MSB=1.
//   Bounded: at most WIDTH-1 cycles; nonzero input guarantees exit.
//  DONE: busy=0, ready=1. Outputs hold until the next load or reset.
//  Latency: load edge k. Result registered at edge k+1.
//   ready is high after edge k+2+n, where n = norm_shift.
//   Example: ready at edge k+2 when no shift is needed.
//  Arithmetic is unsigned on magnitudes. No rounding or sticky handling; that is downstream.
// TESTING (WIDTH=24)
//  1. a=0x800000+, b=0x800000+, op=0 -> c_out=1, sum=0x000000, sign_s=0, norm_shift=0, zero=0, ready 2 cycles after load.
//  2. a=0x800000+, b=0x7FFFFF+, op=1 -> sum=0x800000, norm_shift=23, sign_s=0, ready 25 cycles after load.
//  3. a=0x400000+, b=0xC00000+, op=1 -> sum=0x800000, sign_s=1, norm_shift=0.
//  4. a=0x123456+, b=0x123456-, op=0 -> zero=1, sum=0, sign_s=0, norm_shift=0, ready 2 cycles after load.
//  5. Test 2 with en=0 for 3 cycles mid-NORM -> norm_shift frozen; final result unchanged; ready 3 cycles later.
//     Also assert load during busy -> ignored.
//  6. rst low during NORM -> all outputs 0 immediately (before next edge).
//     After release, load test 3 -> correct result.

Source files
------------

// File: rtl/mant_addsub_norm_if.sv
// Bundle for the mantissa add/sub + normaliser.
// Handshake: the master raises load with operands valid; the slave accepts it
// only on an enabled edge while not busy. Outputs are valid whenever ready=1
// and hold until the next accepted load or reset.
// master: drives load/op/a/b/sign_a/sign_b, observes results.
// slave : consumes operands, drives sum/c_out/sign_s/norm_shift/zero/busy/ready.
interface mant_addsub_norm_if #(
  parameter int WIDTH   = 24,
  parameter int SHIFT_W = 5
);
  logic               load;
  logic               op;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               sign_a;
  logic               sign_b;
  logic [WIDTH-1:0]   sum;
  logic               c_out;
  logic               sign_s;
  logic [SHIFT_W-1:0] norm_shift;
  logic               zero;
  logic               busy;
  logic               ready;

  modport master (
    output load, op, a, b, sign_a, sign_b,
    input  sum, c_out, sign_s, norm_shift, zero, busy, ready
  );

  modport slave (
    input  load, op, a, b, sign_a, sign_b,
    output sum, c_out, sign_s, norm_shift, zero, busy, ready
  );
endinterface

// File: rtl/mant_addsub_norm.sv
// Sign-magnitude mantissa adder/subtractor with a one-bit-per-cycle
// leading-one normaliser, between exponent alignment and rounding.
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-low reset
//   en        clock enable; 0 freezes every register
//   bus       slave side of mant_addsub_norm_if (operands in, result out)
//   state_dbg current FSM state (IDLE=0, ADD=1, NORM=2, DONE=3)
module mant_addsub_norm #(
  parameter int WIDTH   = 24,
  parameter int SHIFT_W = 5,
  parameter int NORM_EN = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  mant_addsub_norm_if.slave bus,
  output logic [1:0]   state_dbg
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADD  = 2'd1;
  localparam logic [1:0] S_NORM = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]         state;
  logic [WIDTH-1:0]   a_r, b_r;
  logic               sign_a_r, sign_b_r, op_r;
  logic [WIDTH-1:0]   sum_q;
  logic               c_out_q, sign_s_q, zero_q, ready_q;
  logic [SHIFT_W-1:0] shift_q;

  // Add phase, computed from the captured operands.
  logic               eff_sub;
  logic [WIDTH:0]     add_full;
  logic               a_ge_b;
  logic [WIDTH-1:0]   diff;
  logic [WIDTH-1:0]   add_sum;
  logic               add_c;
  logic               add_zero;
  logic               add_sign;
  logic               add_done;
  logic [WIDTH-1:0]   shifted;

  always_comb begin
    eff_sub  = op_r ^ sign_a_r ^ sign_b_r;
    add_full = {1'b0, a_r} + {1'b0, b_r};
    a_ge_b   = (a_r >= b_r);
    diff     = a_ge_b ? (a_r - b_r) : (b_r - a_r);
    add_sum  = eff_sub ? diff : add_full[WIDTH-1:0];
    add_c    = eff_sub ? 1'b0 : add_full[WIDTH];
    // A carry with all-zero low bits is not a zero result.
    add_zero = (add_sum == '0) && !add_c;
    if (add_zero)
      add_sign = 1'b0;
    else if (eff_sub && !a_ge_b)
      add_sign = sign_b_r ^ op_r;
    else
      add_sign = sign_a_r;
    add_done = (NORM_EN == 0) || add_c || add_zero || add_sum[WIDTH-1];
    shifted  = sum_q << 1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      a_r      <= '0;
      b_r      <= '0;
      sign_a_r <= 1'b0;
      sign_b_r <= 1'b0;
      op_r     <= 1'b0;
      sum_q    <= '0;
      c_out_q  <= 1'b0;
      sign_s_q <= 1'b0;
      zero_q   <= 1'b0;
      shift_q  <= '0;
      ready_q  <= 1'b0;
    end else if (en) begin
      case (state)
        S_IDLE, S_DONE: begin
          if (bus.load) begin
            a_r      <= bus.a;
            b_r      <= bus.b;
            sign_a_r <= bus.sign_a;
            sign_b_r <= bus.sign_b;
            op_r     <= bus.op;
            shift_q  <= '0;
            ready_q  <= 1'b0;
            state    <= S_ADD;
          end else if (state == S_DONE) begin
            // ready follows DONE by one registered cycle so the result has
            // been stable for a full cycle before it is flagged.
            ready_q <= 1'b1;
          end
        end
        S_ADD: begin
          sum_q    <= add_sum;
          c_out_q  <= add_c;
          sign_s_q <= add_sign;
          zero_q   <= add_zero;
          state    <= add_done ? S_DONE : S_NORM;
        end
        S_NORM: begin
          sum_q   <= shifted;
          shift_q <= shift_q + SHIFT_W'(1);
          // Zero check is only a guard; a nonzero sum always exits on MSB.
          if (shifted[WIDTH-1] || (shifted == '0))
            state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.sum        = sum_q;
  assign bus.c_out      = c_out_q;
  assign bus.sign_s     = sign_s_q;
  assign bus.norm_shift = shift_q;
  assign bus.zero       = zero_q;
  assign bus.busy       = (state == S_ADD) || (state == S_NORM);
  assign bus.ready      = ready_q;
  assign state_dbg      = state;

endmodule

// File: tb/tb_mant_addsub_norm.sv
module tb_mant_addsub_norm;
  localparam int WIDTH   = 24;
  localparam int SHIFT_W = 5;

  logic       clk;
  logic       rst;
  logic       en;
  logic [1:0] state_dbg;

  int n_checks;
  int n_fail;
  int cyc;

  mant_addsub_norm_if #(.WIDTH(WIDTH), .SHIFT_W(SHIFT_W)) bus ();

  mant_addsub_norm #(.WIDTH(WIDTH), .SHIFT_W(SHIFT_W), .NORM_EN(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .bus       (bus.slave),
    .state_dbg (state_dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver: present operands at a negedge, hold load over one rising edge.
  task automatic do_load(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic sa, input logic sb, input logic op);
    @(negedge clk);
    bus.a      = a;
    bus.b      = b;
    bus.sign_a = sa;
    bus.sign_b = sb;
    bus.op     = op;
    bus.load   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.load   = 1'b0;
    cyc = 1;
  endtask

  // Counts rising edges after the load edge until ready is seen.
  task automatic wait_ready(input string tag, input int exp_cycles);
    int c;
    c = cyc;
    while (!bus.ready && c < 200) begin
      @(posedge clk);
      @(negedge clk);
      c++;
    end
    // cyc counts from the load edge; latency is measured in edges after it.
    check({tag, "_latency"}, 32'(c - 1), 32'(exp_cycles));
  endtask

  task automatic check_result(input string tag, input logic [WIDTH-1:0] s, input logic c,
                              input logic sg, input logic [SHIFT_W-1:0] ns, input logic z);
    check({tag, "_sum"},   32'(bus.sum),        32'(s));
    check({tag, "_c_out"}, 32'(bus.c_out),      32'(c));
    check({tag, "_sign"},  32'(bus.sign_s),     32'(sg));
    check({tag, "_shift"}, 32'(bus.norm_shift), 32'(ns));
    check({tag, "_zero"},  32'(bus.zero),       32'(z));
    check({tag, "_busy"},  32'(bus.busy),       32'(0));
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    cyc        = 0;
    rst        = 1'b0;
    en         = 1'b1;
    bus.load   = 1'b0;
    bus.op     = 1'b0;
    bus.a      = '0;
    bus.b      = '0;
    bus.sign_a = 1'b0;
    bus.sign_b = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_sum",   32'(bus.sum),        32'h0);
    check("rst_c_out", 32'(bus.c_out),      32'h0);
    check("rst_sign",  32'(bus.sign_s),     32'h0);
    check("rst_shift", 32'(bus.norm_shift), 32'h0);
    check("rst_zero",  32'(bus.zero),       32'h0);
    check("rst_busy",  32'(bus.busy),       32'h0);
    check("rst_ready", 32'(bus.ready),      32'h0);
    rst = 1'b1;

    // 1: effective add with carry-out, no normalisation
    do_load(24'h800000, 24'h800000, 1'b0, 1'b0, 1'b0);
    check("t1_busy", 32'(bus.busy), 32'h1);
    wait_ready("t1", 2);
    check_result("t1", 24'h000000, 1'b1, 1'b0, 5'd0, 1'b0);

    // 2: massive cancellation, 23 shifts
    do_load(24'h800000, 24'h7FFFFF, 1'b0, 1'b0, 1'b1);
    wait_ready("t2", 25);
    check_result("t2", 24'h800000, 1'b0, 1'b0, 5'd23, 1'b0);

    // 3: b > a, result negative, no shift
    do_load(24'h400000, 24'hC00000, 1'b0, 1'b0, 1'b1);
    wait_ready("t3", 2);
    check_result("t3", 24'h800000, 1'b0, 1'b1, 5'd0, 1'b0);

    // 4: x + (-x) -> positive zero
    do_load(24'h123456, 24'h123456, 1'b0, 1'b1, 1'b0);
    wait_ready("t4", 2);
    check_result("t4", 24'h000000, 1'b0, 1'b0, 5'd0, 1'b1);

    // 5: test 2 with a 3-cycle enable freeze mid-NORM plus a load while busy
    do_load(24'h800000, 24'h7FFFFF, 1'b0, 1'b0, 1'b1);
    repeat (5) begin
      @(posedge clk);
      cyc++;
    end
    @(negedge clk);
    check("t5_shift_pre", 32'(bus.norm_shift), 32'd4);
    en = 1'b0;
    repeat (3) begin
      @(posedge clk);
      cyc++;
    end
    @(negedge clk);
    check("t5_shift_frozen", 32'(bus.norm_shift), 32'd4);
    check("t5_busy_frozen",  32'(bus.busy),       32'h1);
    en         = 1'b1;
    bus.a      = 24'h000001;
    bus.b      = 24'h000002;
    bus.op     = 1'b0;
    bus.load   = 1'b1;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    bus.load   = 1'b0;
    check("t5_load_ignored_shift", 32'(bus.norm_shift), 32'd5);
    wait_ready("t5", 28);
    check_result("t5", 24'h800000, 1'b0, 1'b0, 5'd23, 1'b0);

    // 6: asynchronous reset in the middle of NORM
    do_load(24'h800000, 24'h7FFFFF, 1'b0, 1'b0, 1'b1);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("t6_busy_pre", 32'(bus.busy), 32'h1);
    #1 rst = 1'b0;
    #1;
    check("t6_rst_sum",   32'(bus.sum),        32'h0);
    check("t6_rst_shift", 32'(bus.norm_shift), 32'h0);
    check("t6_rst_busy",  32'(bus.busy),       32'h0);
    check("t6_rst_ready", 32'(bus.ready),      32'h0);
    check("t6_rst_state", 32'(state_dbg),      32'h0);
    @(negedge clk);
    rst = 1'b1;
    do_load(24'h400000, 24'hC00000, 1'b0, 1'b0, 1'b1);
    wait_ready("t6", 2);
    check_result("t6", 24'h800000, 1'b0, 1'b1, 5'd0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
